// File: rtl/pipe_pkg.sv
// Shared ID/EX pipeline types: widths, control bundle, bubble constant and the
// occupancy states of the ID/EX register.
package pipe_pkg;

  localparam int REG_W    = 4;
  localparam int DATA_W   = 32;
  localparam int ALU_OP_W = 4;

  typedef struct packed {
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic                alu_src;
    logic [ALU_OP_W-1:0] alu_op;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t BUBBLE_CTRL = '0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_OCC   = 2'd1,
    ST_HELD  = 2'd2
  } idex_state_t;

  // An invalid instruction may carry stale decode bits; never let them act.
  function automatic id_ex_ctrl_t gate_ctrl(input id_ex_ctrl_t c, input logic v);
    return v ? c : BUBBLE_CTRL;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the load sitting in ID/EX and the ID instruction.
// Purely combinational, zero latency; R0 is never a hazard source.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  output logic             load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX register with load-use bubble, flush and EX hold; 1-cycle latency, stall is combinational.
// Priority flush > ex_hold > load_use > load; ID_EX_PERF_CNT_EN adds stall/bubble counters.
module id_ex_pipe_reg
  import pipe_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_rs1,
  input  logic [REG_W-1:0]    id_rs2,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                id_mem_to_reg,
  input  logic                id_alu_src,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic [DATA_W-1:0]   id_rd1_data,
  input  logic [DATA_W-1:0]   id_rd2_data,
  input  logic [DATA_W-1:0]   id_imm,
  input  logic                flush,
  input  logic                ex_hold,
  output logic                valid_idex,
  output logic [REG_W-1:0]    rs1_idex,
  output logic [REG_W-1:0]    rs2_idex,
  output logic [REG_W-1:0]    rd_idex,
  output logic                reg_write_en_idex,
  output logic                mem_read_idex,
  output logic                mem_write_idex,
  output logic                mem_to_reg_idex,
  output logic                alu_src_idex,
  output logic [ALU_OP_W-1:0] alu_op_idex,
  output logic [DATA_W-1:0]   rd1_idex,
  output logic [DATA_W-1:0]   rd2_idex,
  output logic [DATA_W-1:0]   imm_idex,
  output logic                stall
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         bubble_cnt
`endif
);

  idex_state_t          state_q, state_d;
  id_ex_ctrl_t          ctrl_q, ctrl_d;
  id_ex_ctrl_t          id_ctrl;
  logic [REG_W-1:0]     rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [DATA_W-1:0]    rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic                 load_use;

  load_use_detect u_load_use_detect (
    .ex_valid    (valid_idex),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rd       (rd_q),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .load_use    (load_use)
  );

  always_comb begin
    id_ctrl.reg_write  = id_reg_write;
    id_ctrl.mem_read   = id_mem_read;
    id_ctrl.mem_write  = id_mem_write;
    id_ctrl.mem_to_reg = id_mem_to_reg;
    id_ctrl.alu_src    = id_alu_src;
    id_ctrl.alu_op     = id_alu_op;
  end

  // A flush squashes even a held EX slot, so it must not raise stall.
  assign stall = !flush && (ex_hold || load_use);

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    if (flush || (!ex_hold && load_use)) begin
      state_d = ST_EMPTY;
      ctrl_d  = BUBBLE_CTRL;
      rs1_d   = '0;
      rs2_d   = '0;
      rd_d    = '0;
      rd1_d   = '0;
      rd2_d   = '0;
      imm_d   = '0;
    end else if (ex_hold) begin
      state_d = (state_q == ST_EMPTY) ? ST_EMPTY : ST_HELD;
    end else begin
      state_d = id_valid ? ST_OCC : ST_EMPTY;
      ctrl_d  = gate_ctrl(id_ctrl, id_valid);
      rs1_d   = id_rs1;
      rs2_d   = id_rs2;
      rd_d    = id_rd;
      rd1_d   = id_rd1_data;
      rd2_d   = id_rd2_data;
      imm_d   = id_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ctrl_q  <= BUBBLE_CTRL;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
    end
  end

  assign valid_idex        = (state_q != ST_EMPTY);
  assign rs1_idex          = rs1_q;
  assign rs2_idex          = rs2_q;
  assign rd_idex           = rd_q;
  assign reg_write_en_idex = ctrl_q.reg_write;
  assign mem_read_idex     = ctrl_q.mem_read;
  assign mem_write_idex    = ctrl_q.mem_write;
  assign mem_to_reg_idex   = ctrl_q.mem_to_reg;
  assign alu_src_idex      = ctrl_q.alu_src;
  assign alu_op_idex       = ctrl_q.alu_op;
  assign rd1_idex          = rd1_q;
  assign rd2_idex          = rd2_q;
  assign imm_idex          = imm_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic        bubble_evt;

  // A load-use bubble only happens when ex_hold does not take precedence.
  assign bubble_evt = flush || (!ex_hold && load_use);

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (bubble_evt && (bubble_cnt_q != '1)) bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: expected ID/EX contents are queued when
// inputs are driven and compared after the following rising edge.
module tb_id_ex_pipe_reg;
  import pipe_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                id_valid;
  logic [REG_W-1:0]    id_rs1, id_rs2, id_rd;
  logic                id_use_rs1, id_use_rs2;
  logic                id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src;
  logic [ALU_OP_W-1:0] id_alu_op;
  logic [DATA_W-1:0]   id_rd1_data, id_rd2_data, id_imm;
  logic                flush, ex_hold;
  logic                valid_idex;
  logic [REG_W-1:0]    rs1_idex, rs2_idex, rd_idex;
  logic                reg_write_en_idex, mem_read_idex, mem_write_idex, mem_to_reg_idex, alu_src_idex;
  logic [ALU_OP_W-1:0] alu_op_idex;
  logic [DATA_W-1:0]   rd1_idex, rd2_idex, imm_idex;
  logic                stall;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0]         stall_cnt, bubble_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
    .id_rd1_data(id_rd1_data), .id_rd2_data(id_rd2_data), .id_imm(id_imm),
    .flush(flush), .ex_hold(ex_hold),
    .valid_idex(valid_idex), .rs1_idex(rs1_idex), .rs2_idex(rs2_idex), .rd_idex(rd_idex),
    .reg_write_en_idex(reg_write_en_idex), .mem_read_idex(mem_read_idex),
    .mem_write_idex(mem_write_idex), .mem_to_reg_idex(mem_to_reg_idex),
    .alu_src_idex(alu_src_idex), .alu_op_idex(alu_op_idex),
    .rd1_idex(rd1_idex), .rd2_idex(rd2_idex), .imm_idex(imm_idex),
    .stall(stall)
`ifdef ID_EX_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  typedef struct packed {
    logic        valid;
    logic [3:0]  rs1, rs2, rd;
    logic        rw, mr, mw, m2r, as;
    logic [3:0]  op;
    logic [31:0] rd1, rd2, imm;
  } obs_t;

  typedef struct packed {
    logic        v;
    logic [3:0]  r1, r2, rd;
    logic        u1, u2, rw, mr, mw, m2r, as;
    logic [3:0]  op;
    logic [31:0] d1, d2, im;
    logic        fl, hold;
  } vec_t;

  obs_t m;
  obs_t exp_q[$];
  logic exp_stall;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic obs_t sample();
    obs_t o;
    o = {valid_idex, rs1_idex, rs2_idex, rd_idex, reg_write_en_idex, mem_read_idex,
         mem_write_idex, mem_to_reg_idex, alu_src_idex, alu_op_idex, rd1_idex, rd2_idex, imm_idex};
    return o;
  endfunction

  function automatic vec_t mk_load(input logic [3:0] rd, input logic [3:0] base);
    vec_t t = '0;
    t.v = 1'b1; t.r1 = base; t.u1 = 1'b1; t.rd = rd;
    t.rw = 1'b1; t.mr = 1'b1; t.m2r = 1'b1; t.as = 1'b1;
    t.d1 = 32'h1000_0000 + 32'(base); t.im = 32'h4;
    return t;
  endfunction

  function automatic vec_t mk_alu(input logic [3:0] r1, input logic [3:0] r2,
                                  input logic [3:0] rd, input logic [31:0] imm);
    vec_t t = '0;
    t.v = 1'b1; t.r1 = r1; t.r2 = r2; t.rd = rd; t.u1 = 1'b1; t.u2 = 1'b1;
    t.rw = 1'b1; t.op = 4'h2; t.d1 = 32'hA5A5_0000 | 32'(r1); t.d2 = 32'h5A5A_0000 | 32'(r2);
    t.im = imm;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    id_valid = t.v; id_rs1 = t.r1; id_rs2 = t.r2; id_rd = t.rd;
    id_use_rs1 = t.u1; id_use_rs2 = t.u2;
    id_reg_write = t.rw; id_mem_read = t.mr; id_mem_write = t.mw;
    id_mem_to_reg = t.m2r; id_alu_src = t.as; id_alu_op = t.op;
    id_rd1_data = t.d1; id_rd2_data = t.d2; id_imm = t.im;
    flush = t.fl; ex_hold = t.hold;
  endtask

  // Reference behaviour: expected stall for the current inputs and the next ID/EX contents.
  task automatic model();
    logic lu;
    obs_t nxt;
    lu = m.valid && m.mr && (m.rd != 4'd0) && id_valid &&
         ((id_use_rs1 && id_rs1 == m.rd) || (id_use_rs2 && id_rs2 == m.rd));
    exp_stall = !flush && (ex_hold || lu);
    if (flush) nxt = '0;
    else if (ex_hold) nxt = m;
    else if (lu) nxt = '0;
    else begin
      nxt.valid = id_valid;
      nxt.rs1 = id_rs1; nxt.rs2 = id_rs2; nxt.rd = id_rd;
      nxt.rw = id_reg_write & id_valid; nxt.mr = id_mem_read & id_valid;
      nxt.mw = id_mem_write & id_valid; nxt.m2r = id_mem_to_reg & id_valid;
      nxt.as = id_alu_src & id_valid; nxt.op = id_alu_op & {4{id_valid}};
      nxt.rd1 = id_rd1_data; nxt.rd2 = id_rd2_data; nxt.imm = id_imm;
    end
    m = nxt;
    exp_q.push_back(nxt);
  endtask

  task automatic do_reset();
    drive('0);
    rst_n = 1'b0;
    #3;
    m = '0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t got;
    rst_n = 1'b0;
    drive(mk_alu(4'd1, 4'd2, 4'd3, 32'h55));
    for (int i = 0; i < 2; i++) begin
      #2;
      got = sample();
      n_vec++;
      if (got !== obs_t'(0)) begin n_err++; $display("FAIL reset_outputs[%0d]: got %h expected 0", i, got); end
      n_vec++;
      if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall[%0d]: got %b expected 0", i, stall); end
      @(posedge clk); #1;
    end
    m = '0;
    exp_q.delete();
    rst_n = 1'b1;
    #1; model();
    @(posedge clk); #1;
    got = sample();
    n_vec++;
    if (got !== exp_q.pop_front() || valid_idex !== 1'b1 || rd_idex !== 4'd3) begin
      n_err++; $display("FAIL reset_first_load: got %h valid=%b rd=%0d expected rd=3 valid=1", got, valid_idex, rd_idex);
    end
  endtask

  // Runs a table of input vectors through the scoreboard; returns per-step stall and valid.
  task automatic run_table(input string name, input vec_t tv[], output logic st[], output logic vl[]);
    obs_t got, exp;
    st = new[tv.size()];
    vl = new[tv.size()];
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i]);
      #1; model();
      n_vec++;
      if (stall !== exp_stall) begin n_err++; $display("FAIL %s_stall[%0d]: got %b expected %b", name, i, stall, exp_stall); end
      st[i] = stall;
      @(posedge clk); #1;
      got = sample();
      exp = exp_q.pop_front();
      n_vec++;
      if (got !== exp) begin n_err++; $display("FAIL %s_regs[%0d]: got %h expected %h", name, i, got, exp); end
      vl[i] = valid_idex;
    end
  endtask

  task automatic test_load_use();
    vec_t tv[];
    logic st[], vl[];
    tv = new[4];
    tv[0] = mk_load(4'd3, 4'd1);
    tv[1] = mk_alu(4'd3, 4'd2, 4'd4, 32'h7);
    tv[2] = tv[1];
    tv[3] = '0;
    run_table("load_use", tv, st, vl);
    n_vec++;
    if (st[1] !== 1'b1 || st[2] !== 1'b0 || vl[1] !== 1'b0 || vl[2] !== 1'b1) begin
      n_err++; $display("FAIL load_use_seq: stall=%b%b valid=%b%b expected stall=10 valid=01", st[1], st[2], vl[1], vl[2]);
    end
  endtask

  task automatic test_r0_no_hazard();
    vec_t tv[];
    logic st[], vl[];
    tv = new[2];
    tv[0] = mk_load(4'd0, 4'd1);
    tv[1] = mk_alu(4'd0, 4'd0, 4'd5, 32'h9);
    run_table("r0", tv, st, vl);
    n_vec++;
    if (st[1] !== 1'b0 || vl[1] !== 1'b1 || rd_idex !== 4'd5) begin
      n_err++; $display("FAIL r0_no_bubble: stall=%b valid=%b rd=%0d expected 0 1 5", st[1], vl[1], rd_idex);
    end
  endtask

  task automatic test_hold();
    vec_t tv[];
    logic st[], vl[];
    tv = new[5];
    tv[0] = mk_alu(4'd1, 4'd2, 4'd5, 32'h10);
    for (int i = 1; i < 4; i++) begin
      tv[i] = mk_alu(4'd6, 4'd7, 4'd8, 32'h99);
      tv[i].hold = 1'b1;
    end
    tv[4] = mk_alu(4'd6, 4'd7, 4'd8, 32'h99);
    run_table("hold", tv, st, vl);
    n_vec++;
    if (st[1] !== 1'b1 || st[2] !== 1'b1 || st[3] !== 1'b1 || st[4] !== 1'b0 || rd_idex !== 4'd8 || imm_idex !== 32'h99) begin
      n_err++; $display("FAIL hold_release: stall=%b%b%b%b rd=%0d imm=%h expected 1110 8 99", st[1], st[2], st[3], st[4], rd_idex, imm_idex);
    end
  endtask

  task automatic test_flush_priority();
    vec_t tv[];
    logic st[], vl[];
    tv = new[2];
    tv[0] = mk_load(4'd3, 4'd1);
    tv[1] = mk_alu(4'd3, 4'd2, 4'd4, 32'h1);
    tv[1].fl = 1'b1;
    tv[1].hold = 1'b1;
    run_table("flush", tv, st, vl);
    n_vec++;
    if (st[1] !== 1'b0 || vl[1] !== 1'b0 || reg_write_en_idex !== 1'b0 || mem_read_idex !== 1'b0) begin
      n_err++; $display("FAIL flush_wins: stall=%b valid=%b rw=%b mr=%b expected all 0", st[1], vl[1], reg_write_en_idex, mem_read_idex);
    end
  endtask

  task automatic test_hold_with_load_use();
    vec_t tv[];
    logic st[], vl[];
    tv = new[4];
    tv[0] = mk_load(4'd3, 4'd1);
    tv[1] = mk_alu(4'd2, 4'd3, 4'd4, 32'h2);
    tv[1].hold = 1'b1;
    tv[2] = mk_alu(4'd2, 4'd3, 4'd4, 32'h2);
    tv[3] = tv[2];
    run_table("hold_lu", tv, st, vl);
    n_vec++;
    if (st[1] !== 1'b1 || vl[1] !== 1'b1 || st[2] !== 1'b1 || vl[2] !== 1'b0 || st[3] !== 1'b0 || vl[3] !== 1'b1) begin
      n_err++; $display("FAIL hold_lu_seq: stall=%b%b%b valid=%b%b%b expected 110 101", st[1], st[2], st[3], vl[1], vl[2], vl[3]);
    end
  endtask

  task automatic test_back_to_back();
    vec_t tv[];
    logic st[], vl[];
    tv = new[250];
    for (int i = 0; i < 250; i++) begin
      tv[i].v    = ($urandom_range(0, 7) != 0);
      tv[i].r1   = 4'($urandom_range(0, 3));
      tv[i].r2   = 4'($urandom_range(0, 3));
      tv[i].rd   = 4'($urandom_range(0, 3));
      tv[i].u1   = 1'($urandom_range(0, 1));
      tv[i].u2   = 1'($urandom_range(0, 1));
      tv[i].rw   = 1'($urandom_range(0, 1));
      tv[i].mr   = 1'($urandom_range(0, 1));
      tv[i].mw   = 1'($urandom_range(0, 1));
      tv[i].m2r  = 1'($urandom_range(0, 1));
      tv[i].as   = 1'($urandom_range(0, 1));
      tv[i].op   = 4'($urandom_range(0, 15));
      tv[i].d1   = $urandom;
      tv[i].d2   = $urandom;
      tv[i].im   = $urandom;
      tv[i].fl   = ($urandom_range(0, 9) == 0);
      tv[i].hold = ($urandom_range(0, 5) == 0);
    end
    run_table("b2b", tv, st, vl);
  endtask

  task automatic test_reset_mid_stall();
    vec_t tv[];
    vec_t hv;
    logic st[], vl[];
    obs_t got;
    tv = new[1];
    tv[0] = mk_load(4'd3, 4'd1);
    run_table("rst_mid", tv, st, vl);
    hv = mk_alu(4'd3, 4'd2, 4'd4, 32'h3);
    hv.hold = 1'b1;
    drive(hv);
    #2;
    n_vec++;
    if (stall !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre_stall: got %b expected 1", stall); end
    rst_n = 1'b0;
    #1;
    got = sample();
    n_vec++;
    if (got !== obs_t'(0)) begin n_err++; $display("FAIL rst_mid_clear: got %h expected 0", got); end
    hv.hold = 1'b0;
    drive(hv);
    #1;
    n_vec++;
    if (stall !== 1'b0) begin n_err++; $display("FAIL rst_mid_stall: got %b expected 0", stall); end
    m = '0;
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    tv[0] = hv;
    run_table("rst_mid_after", tv, st, vl);
    n_vec++;
    if (st[0] !== 1'b0 || vl[0] !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_no_pending: stall=%b valid=%b expected 0 1", st[0], vl[0]);
    end
  endtask

`ifdef ID_EX_PERF_CNT_EN
  task automatic test_perf_cnt();
    vec_t tv[];
    logic st[], vl[];
    do_reset();
    tv = new[11];
    tv[0]  = mk_load(4'd3, 4'd1);
    tv[1]  = mk_alu(4'd3, 4'd2, 4'd4, 32'h1);
    tv[2]  = tv[1];
    tv[3]  = mk_load(4'd5, 4'd1);
    tv[4]  = mk_alu(4'd1, 4'd5, 4'd6, 32'h2);
    tv[5]  = tv[4];
    for (int i = 6; i < 9; i++) begin
      tv[i] = mk_alu(4'd7, 4'd8, 4'd9, 32'h3);
      tv[i].hold = 1'b1;
    end
    tv[9]  = mk_alu(4'd7, 4'd8, 4'd9, 32'h3);
    tv[10] = '0;
    tv[10].fl = 1'b1;
    run_table("perf", tv, st, vl);
    n_vec++;
    if (bubble_cnt !== 32'd3 || stall_cnt !== 32'd5) begin
      n_err++; $display("FAIL perf_cnt: bubble=%0d stall=%0d expected 3 5", bubble_cnt, stall_cnt);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    m = '0;
    test_reset();
    test_load_use();
    test_r0_no_hazard();
    test_hold();
    test_flush_priority();
    test_hold_with_load_use();
    test_back_to_back();
    test_reset_mid_stall();
`ifdef ID_EX_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

ID/EX pipeline register with integrated load-use hazard detection, bubble insertion and flush. Sits between decode and execute. Captures decoded operands and control each cycle. Its registered outputs (rs1_idex, rs2_idex, rd_idex, reg_write_en_idex, …) drive the forwarding unit and EX-stage operand muxes. Its stall output freezes PC and IF/ID on load-use or EX back-pressure.

## Interface
- DATA_W, 32, operand/immediate width
- REG_W, 4, register index width
- ALU_OP_W, 4, ALU opcode width
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2, id_rd  in  REG_W  decoded register indices
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1/rs2
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src  in  1  decoded control
- id_alu_op  in  ALU_OP_W  ALU operation
- id_rd1_data, id_rd2_data, id_imm  in  DATA_W  register-file reads, immediate
- flush  in  1  EX branch taken; squash ID instruction
- ex_hold  in  1  EX multi-cycle busy; retain ID/EX contents
- valid_idex, rs1_idex, rs2_idex, rd_idex, reg_write_en_idex, mem_read_idex, mem_write_idex, mem_to_reg_idex, alu_src_idex, alu_op_idex, rd1_idex, rd2_idex, imm_idex  out  registered copies of the matching inputs
- stall  out  1  combinational; hold PC and IF/ID this cycle

## Operation
- load_use = valid_idex & mem_read_idex & (rd_idex != 0) & id_valid & ((id_use_rs1 & id_rs1 == rd_idex) | (id_use_rs2 & id_rs2 == rd_idex)).
- R0 is never a hazard source, which matches forwarding.
- stall = ~flush & (ex_hold | load_use).
- Per-edge update, highest priority first:
  - flush → bubble.
  - ex_hold → retain all fields.
  - load_use → bubble; the ID instruction stays upstream and is captured next cycle.
  - otherwise → load ID fields. valid_idex = id_valid. Control bits are ANDed with id_valid.
- Bubble: valid_idex = 0. All control outputs = 0. rs1/rs2/rd_idex = 0. Data outputs = 0.
- Loaded invalid instruction: control = 0. Indices and data are still copied.
- States: EMPTY (valid_idex=0), OCC (valid_idex=1), HELD (OCC with ex_hold).
  - EMPTY/OCC → OCC on load with id_valid.
  - Any state → EMPTY on flush, on load_use bubble, or on load with ~id_valid.
  - OCC → HELD while ex_hold & ~flush.

## Timing
- Latency: one cycle, ID input to *_idex output.
- Reset (async assert, sync-safe deassert): all outputs 0. valid_idex = 0. stall then follows its inputs (0 with idle inputs).
- A load-use stall lasts exactly 1 cycle. The next cycle the load is in EX/MEM, the bubble is in ID/EX, and load_use = 0.
- ex_hold held N cycles → stall high N cycles; contents unchanged throughout.
- flush together with ex_hold or load_use → flush wins: stall = 0, bubble inserted.
- ex_hold together with load_use → stall = 1, contents retained, no bubble. Hazard is re-evaluated after the hold.
- Reset mid-stall: outputs clear immediately. No pending bubble survives.

## Configuration
- ID_EX_PERF_CNT_EN defined: adds outputs stall_cnt and bubble_cnt, 32 bits each, saturating at all-ones, reset to 0.
  - stall_cnt increments every cycle stall = 1.
  - bubble_cnt increments on every load_use or flush bubble.
- ID_EX_PERF_CNT_EN undefined: ports and counters absent. Behaviour otherwise identical.

## Structure
- Shared pipe_pkg holds:
  - REG_W, DATA_W, ALU_OP_W constants.
  - id_ex_ctrl_t struct: reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op.
  - BUBBLE_CTRL constant (all zero).
- Sub-module load_use_detect: combinational hazard compare, reusable by a future second issue slot.
- Top module holds the register and the priority mux.

## Test plan
- Reset with id_valid=1 driven → all *_idex = 0 and stall = 0 during reset. First edge after release loads ID fields.
- LDR R3 in ID/EX (mem_read=1, rd=3); ID has ADD using rs1=3 → stall=1 for one cycle. Next edge: valid_idex=0. Following edge: ADD loaded with rs1_idex=3.
- LDR R0 in ID/EX; ID reads R0 → stall=0, no bubble.
- ex_hold high 3 cycles with rd_idex=5, imm_idex=0x10 → stall high 3 cycles, outputs unchanged. Releases on the 4th edge.
- flush with load_use and ex_hold all asserted → stall=0, next edge valid_idex=0 with all control 0.
- With ID_EX_PERF_CNT_EN: 2 load-use bubbles, 1 flush, 3 hold cycles → bubble_cnt=3, stall_cnt=5.
